csi2_rx_depacketizer: RTL and testbench
=======================================

CSI2_RX_DEPACKETIZER -- requirements
Module: csi2_rx_depacketizer

Interface
REQ-001 Parameter VC, default 0: virtual channel accepted; packets with any other VC are dropped.
REQ-002 Parameter DT, default 6'h1E: long-packet data type accepted (YUV422 8-bit); other long DTs are dropped.
REQ-003 Parameter MAX_WC, default 16'h0F00: largest legal word count in bytes.
REQ-004 clk  in  1  byte clock; the only clock; all logic on its rising edge.
REQ-005 reset  in  1  reset; synchronous, active-high.
REQ-006 hs_valid  in  1  high while a burst is active on the 4 lanes, SoT already stripped.
REQ-007 hs_data  in  32  merged lane bytes; lane0 = [7:0], lane3 = [31:24].
REQ-008 fv  out  1  frame valid.
REQ-009 lv  out  1  line valid.
REQ-010 pix_valid  out  1  pix_data holds 4 payload bytes.
REQ-011 pix_data  out  32  payload bytes, byte order as received.
REQ-012 ecc_err  out  1  one-cycle pulse on header ECC mismatch.
REQ-013 crc_err  out  1  one-cycle pulse on payload CRC mismatch.
REQ-014 pkt_err  out  1  one-cycle pulse on truncation, illegal WC, or WC not a multiple of 4.

Function
REQ-015 State machine: IDLE, PAYLOAD, CRC, DRAIN.
- IDLE: the first hs_valid word is the header. DI = byte0, WC = {byte2, byte1}, ECC = byte3.
- DRAIN: wait for hs_valid low, then go to IDLE.
REQ-016 Header ECC is the CSI-2 6-bit Hamming code over the 24 header bits, compared against ECC[5:0].
- Mismatch: pulse ecc_err, take no action, go to DRAIN.
- No error correction is performed.
REQ-017 Short packets with VC match, decoded in IDLE one cycle after the header word, then DRAIN:
- DT 0x00 (FS): fv=1.
- DT 0x01 (FE): fv=0, lv=0.
- DT 0x02/0x03 (LS/LE): ignored.
REQ-018 Long packet with VC and DT match, WC nonzero, WC <= MAX_WC and WC%4 == 0: set lv=1, load word counter with WC/4, go to PAYLOAD; otherwise pulse pkt_err and DRAIN.
REQ-019 PAYLOAD: each hs_valid word goes to pix_data with pix_valid=1 exactly one cycle later; counter decrements; counter reaching 0 goes to CRC.
REQ-020 CRC: the word carries CRC LSB in byte0 and MSB in byte1; bytes 2-3 are ignored.
- lv=0 on the cycle after the CRC word.
- Go to DRAIN.
REQ-021 hs_valid low while in PAYLOAD or CRC:
- pulse pkt_err, lv=0 next cycle, go to IDLE;
- no partial CRC check;
- fv unchanged.
REQ-022 hs_valid low in DRAIN goes to IDLE on the same edge.
- A new header is accepted only after at least one idle cycle.
REQ-023 FS while fv=1 re-asserts fv (no error); FE while fv=0 is ignored.
REQ-024 Error pulses and pix_valid are never asserted in the same cycle for different packets.

Reset
REQ-025 On reset:
- state=IDLE, counter=0;
- fv, lv, pix_valid, ecc_err, crc_err, pkt_err all 0;
- pix_data=0.
REQ-026 Reset mid-packet discards the packet and produces no error pulse; the next header is parsed only after reset deasserts and hs_valid is seen low.

Configuration
REQ-027 Macro CSI2_RX_CRC_CHECK_EN defined: CRC-16 is computed over the payload (poly x^16+x^12+x^5+1, reflected 0x8408, init 0xFFFF, 4 bytes/cycle); mismatch pulses crc_err on the cycle after the CRC word.
REQ-028 Macro undefined: no CRC logic is present; crc_err is tied to 0; the CRC word is consumed unchecked.

Structure
REQ-029 Shared package csi2_pkg holds:
- DT constants: FS, FE, LS, LE, YUV422_8;
- the state enum;
- the ECC function.
REQ-030 Sub-module csi2_crc16: 32-bit-per-cycle CRC engine with init/enable, present only under CSI2_RX_CRC_CHECK_EN.

Verification
REQ-031 The bench shall cover the following directed scenarios:
- FS short packet (header 0x00,0x00,0x00,ECC) -> fv=1 two cycles later, no error pulses.
- Long packet DT 0x1E, WC 0x01E0, 120 payload words, correct CRC -> 120 pix_valid cycles with matching data, lv high throughout, crc_err=0.
- Same packet with one payload bit flipped -> crc_err pulse once (macro defined); crc_err=0 (macro undefined).
- Header ECC bit flipped -> ecc_err pulse, no lv, no pix_valid.
- hs_valid dropped after 10 payload words -> pkt_err pulse, lv=0, then the next FE sets fv=0.
- WC 0x01E2 -> pkt_err, no pix_valid; reset asserted mid-payload -> all outputs 0 next cycle.

Source files
------------

// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data-type codes, depacketizer state encoding and
// the packet-header ECC (6-bit Hamming code over DI + WC).
package csi2_pkg;

  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_YUV422_8 = 6'h1E;

  // Data types below this value are short packets.
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // d = {WC[15:8], WC[7:0], DI}; result is compared against ECC[5:0].
  function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

endpackage

// File: rtl/csi2_rx_depacketizer_if.sv
// Bus bundle between the merged 4-lane byte stream and the pixel side.
// Handshake: there is no backpressure. hs_valid qualifies hs_data on every
// rising clk edge while a burst is active; pix_valid qualifies pix_data for
// exactly one cycle per 4-byte payload word. fv/lv are levels, the *_err
// signals are single-cycle pulses.
interface csi2_rx_depacketizer_if;
  logic        hs_valid;
  logic [31:0] hs_data;
  logic        fv;
  logic        lv;
  logic        pix_valid;
  logic [31:0] pix_data;
  logic        ecc_err;
  logic        crc_err;
  logic        pkt_err;

  modport master (
    output hs_valid, hs_data,
    input  fv, lv, pix_valid, pix_data, ecc_err, crc_err, pkt_err
  );

  modport slave (
    input  hs_valid, hs_data,
    output fv, lv, pix_valid, pix_data, ecc_err, crc_err, pkt_err
  );
endinterface

// File: rtl/csi2_crc16.sv
// CRC-16 engine for CSI-2 payload, 32 bits per cycle, byte0 (lane0) first,
// LSB first within a byte. Reflected polynomial 0x8408, seed 0xFFFF.
// Only built when CSI2_RX_CRC_CHECK_EN is defined.
`ifdef CSI2_RX_CRC_CHECK_EN
module csi2_crc16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [31:0] data,
  output logic [15:0] crc
);

  function automatic logic [15:0] crc_step32(input logic [15:0] c_in,
                                             input logic [31:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 32; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  // init together with en seeds the CRC and folds in the first word at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc <= 16'hFFFF;
    end else if (en) begin
      crc <= crc_step32(init ? 16'hFFFF : crc, data);
    end else if (init) begin
      crc <= 16'hFFFF;
    end
  end

endmodule
`endif

// File: rtl/csi2_rx_depacketizer.sv
// CSI-2 receive depacketizer: parses headers from the merged 4-lane stream,
// tracks frame/line valid from FS/FE and accepted long packets, and forwards
// payload words one cycle after they arrive. Optional payload CRC checking is
// enabled by defining CSI2_RX_CRC_CHECK_EN; otherwise crc_err is constant 0.
module csi2_rx_depacketizer
  import csi2_pkg::*;
#(
  parameter logic [1:0]  VC     = 2'd0,
  parameter logic [5:0]  DT     = DT_YUV422_8,
  parameter logic [15:0] MAX_WC = 16'h0F00
) (
  input  logic                   clk,
  input  logic                   reset,
  csi2_rx_depacketizer_if.slave  bus,
  output state_t                 dbg_state
);

  state_t      state, state_n;
  logic        hdr_pending, hdr_pending_n;
  logic        hdr_take;
  logic        hs_valid_q;
  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic [5:0]  hdr_ecc;
  logic [13:0] cnt, cnt_n;
  logic        fv, fv_n;
  logic        lv, lv_n;
  logic        pix_valid, pix_valid_n;
  logic [31:0] pix_data, pix_data_n;
  logic        ecc_err, ecc_err_n;
  logic        pkt_err, pkt_err_n;

  logic        hdr_ok;
  logic        wc_ok;
  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;

  assign hdr_dt = hdr_di[5:0];
  assign hdr_vc = hdr_di[7:6];
  assign hdr_ok = (csi2_ecc({hdr_wc, hdr_di}) == hdr_ecc);
  assign wc_ok  = (hdr_wc != 16'h0000) && (hdr_wc <= MAX_WC) &&
                  (hdr_wc[1:0] == 2'b00);

`ifdef CSI2_RX_CRC_CHECK_EN
  logic        crc_init, crc_en;
  logic [15:0] crc_val;
  logic        crc_err_r, crc_err_n;

  csi2_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (crc_init),
    .en    (crc_en),
    .data  (bus.hs_data),
    .crc   (crc_val)
  );
`endif

  // Next-state and next-output decode. A header is only taken on the first
  // valid word after hs_valid was low, and is decoded in the following cycle;
  // for an accepted long packet that following word is already payload.
  always_comb begin
    state_n       = state;
    hdr_pending_n = 1'b0;
    hdr_take      = 1'b0;
    cnt_n         = cnt;
    fv_n          = fv;
    lv_n          = lv;
    pix_valid_n   = 1'b0;
    pix_data_n    = pix_data;
    ecc_err_n     = 1'b0;
    pkt_err_n     = 1'b0;
`ifdef CSI2_RX_CRC_CHECK_EN
    crc_init      = 1'b0;
    crc_en        = 1'b0;
    crc_err_n     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (hdr_pending) begin
          state_n = bus.hs_valid ? ST_DRAIN : ST_IDLE;
          if (!hdr_ok) begin
            ecc_err_n = 1'b1;
          end else if (hdr_vc == VC) begin
            if (hdr_dt < DT_LONG_MIN) begin
              case (hdr_dt)
                DT_FS:        fv_n = 1'b1;
                DT_FE: begin
                  fv_n = 1'b0;
                  lv_n = 1'b0;
                end
                DT_LS, DT_LE: ;
                default:      ;
              endcase
            end else if (hdr_dt == DT) begin
              if (!wc_ok || !bus.hs_valid) begin
                pkt_err_n = 1'b1;
              end else begin
                lv_n        = 1'b1;
                pix_valid_n = 1'b1;
                pix_data_n  = bus.hs_data;
                cnt_n       = hdr_wc[15:2] - 14'd1;
                state_n     = (hdr_wc[15:2] == 14'd1) ? ST_CRC : ST_PAYLOAD;
`ifdef CSI2_RX_CRC_CHECK_EN
                crc_init    = 1'b1;
                crc_en      = 1'b1;
`endif
              end
            end
          end
        end else if (bus.hs_valid && !hs_valid_q) begin
          hdr_take      = 1'b1;
          hdr_pending_n = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (!bus.hs_valid) begin
          pkt_err_n = 1'b1;
          lv_n      = 1'b0;
          state_n   = ST_IDLE;
        end else begin
          pix_valid_n = 1'b1;
          pix_data_n  = bus.hs_data;
          cnt_n       = cnt - 14'd1;
          if (cnt == 14'd1) state_n = ST_CRC;
`ifdef CSI2_RX_CRC_CHECK_EN
          crc_en      = 1'b1;
`endif
        end
      end
      ST_CRC: begin
        if (!bus.hs_valid) begin
          pkt_err_n = 1'b1;
          lv_n      = 1'b0;
          state_n   = ST_IDLE;
        end else begin
          lv_n    = 1'b0;
          state_n = ST_DRAIN;
`ifdef CSI2_RX_CRC_CHECK_EN
          crc_err_n = (crc_val != bus.hs_data[15:0]);
`endif
        end
      end
      ST_DRAIN: begin
        if (!bus.hs_valid) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers; hs_valid_q resets high so a burst already in
  // flight when reset releases is ignored until the line goes idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      hdr_pending <= 1'b0;
      hs_valid_q  <= 1'b1;
      hdr_di      <= 8'h00;
      hdr_wc      <= 16'h0000;
      hdr_ecc     <= 6'h00;
      cnt         <= 14'd0;
      fv          <= 1'b0;
      lv          <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= 32'h0;
      ecc_err     <= 1'b0;
      pkt_err     <= 1'b0;
    end else begin
      state       <= state_n;
      hdr_pending <= hdr_pending_n;
      hs_valid_q  <= bus.hs_valid;
      cnt         <= cnt_n;
      fv          <= fv_n;
      lv          <= lv_n;
      pix_valid   <= pix_valid_n;
      pix_data    <= pix_data_n;
      ecc_err     <= ecc_err_n;
      pkt_err     <= pkt_err_n;
      if (hdr_take) begin
        hdr_di  <= bus.hs_data[7:0];
        hdr_wc  <= bus.hs_data[23:8];
        hdr_ecc <= bus.hs_data[29:24];
      end
    end
  end

`ifdef CSI2_RX_CRC_CHECK_EN
  // CRC mismatch pulse, raised the cycle after the CRC word.
  always_ff @(posedge clk) begin
    if (reset) crc_err_r <= 1'b0;
    else       crc_err_r <= crc_err_n;
  end
  assign bus.crc_err = crc_err_r;
`else
  assign bus.crc_err = 1'b0;
`endif

  assign bus.fv        = fv;
  assign bus.lv        = lv;
  assign bus.pix_valid = pix_valid;
  assign bus.pix_data  = pix_data;
  assign bus.ecc_err   = ecc_err;
  assign bus.pkt_err   = pkt_err;
  assign dbg_state     = state;

endmodule

// File: tb/tb_csi2_rx_depacketizer.sv
// Directed bench for csi2_rx_depacketizer. Expected CRC-error behaviour
// follows CSI2_RX_CRC_CHECK_EN as defined for the build.
module tb_csi2_rx_depacketizer;
  import csi2_pkg::*;

`ifdef CSI2_RX_CRC_CHECK_EN
  localparam logic [31:0] EXP_CRC_FLIP = 32'd1;
`else
  localparam logic [31:0] EXP_CRC_FLIP = 32'd0;
`endif

  // {ECC, WC[15:8], WC[7:0], DI}
  localparam logic [31:0] HDR_FS      = 32'h0000_0000;
  localparam logic [31:0] HDR_FE      = 32'h0700_0001;
  localparam logic [31:0] HDR_LONG    = 32'h0501_E01E;
  localparam logic [31:0] HDR_BAD_ECC = 32'h0401_E01E;
  localparam logic [31:0] HDR_WC_ODD  = 32'h1901_E21E;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  csi2_rx_depacketizer_if bus ();

  csi2_rx_depacketizer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pix, n_extra, n_lv, n_ecc, n_crc, n_pkt;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pay(input int i, input logic [7:0] seed);
    return {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)} ^ {4{seed}};
  endfunction

  // Byte-serial reference CRC-16 (reflected 0x8408), byte0 first.
  function automatic logic [15:0] crc_word(input logic [15:0] c_in,
                                           input logic [31:0] w);
    logic [15:0] c;
    c = c_in;
    for (int b = 0; b < 4; b++) begin
      c = c ^ {8'h00, w[8 * b +: 8]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.pix_valid) begin
      n_pix++;
      if (exp_q.size() == 0) n_extra++;
      else check("pix_data", bus.pix_data, exp_q.pop_front());
    end
    if (bus.lv)      n_lv++;
    if (bus.ecc_err) n_ecc++;
    if (bus.crc_err) n_crc++;
    if (bus.pkt_err) n_pkt++;
  end

  // driver tasks
  task automatic clr_counts();
    n_pix = 0; n_extra = 0; n_lv = 0; n_ecc = 0; n_crc = 0; n_pkt = 0;
    exp_q.delete();
  endtask

  task automatic send_word(input logic [31:0] w);
    @(posedge clk); #1;
    bus.hs_valid = 1'b1;
    bus.hs_data  = w;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.hs_valid = 1'b0;
      bus.hs_data  = 32'h0;
    end
  endtask

  task automatic send_short(input logic [31:0] hdr);
    send_word(hdr);
    idle(6);
  endtask

  // Header, nwords payload words (one bit of word flip_idx flipped after the
  // CRC is computed), CRC word; trunc_at >= 0 drops hs_valid before that word.
  task automatic send_long(input logic [31:0] hdr, input int nwords,
                           input int flip_idx, input int trunc_at,
                           input bit push);
    logic [15:0] c;
    logic [31:0] w;
    bit          cut;
    c   = 16'hFFFF;
    cut = 1'b0;
    send_word(hdr);
    for (int i = 0; i < nwords; i++) begin
      if (i == trunc_at) begin
        cut = 1'b1;
        break;
      end
      w = pay(i, 8'h5A);
      c = crc_word(c, w);
      if (i == flip_idx) w = w ^ 32'h0000_0020;
      if (push) exp_q.push_back(w);
      send_word(w);
    end
    if (!cut) send_word({16'hBEEF, c});
    idle(8);
  endtask

  initial begin
    reset        = 1'b1;
    bus.hs_valid = 1'b0;
    bus.hs_data  = 32'h0;
    clr_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fv",        32'(bus.fv),        32'd0);
    check("rst_lv",        32'(bus.lv),        32'd0);
    check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    check("rst_pix_data",  bus.pix_data,       32'd0);
    check("rst_errs",      32'({bus.ecc_err, bus.crc_err, bus.pkt_err}), 32'd0);
    check("rst_state",     32'(dbg_state),     32'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    idle(3);

    // FS: fv rises two cycles after the header word
    clr_counts();
    send_word(HDR_FS);
    @(posedge clk); #1;
    bus.hs_valid = 1'b0;
    bus.hs_data  = 32'h0;
    @(negedge clk);
    check("fs_fv_decode", 32'(bus.fv), 32'd0);
    @(negedge clk);
    check("fs_fv", 32'(bus.fv), 32'd1);
    idle(4);
    check("fs_errs", 32'(n_ecc + n_crc + n_pkt), 32'd0);

    // good long packet
    clr_counts();
    send_long(HDR_LONG, 120, -1, -1, 1'b1);
    check("long_pix_cnt", 32'(n_pix), 32'd120);
    check("long_extra",   32'(n_extra), 32'd0);
    check("long_q_empty", 32'(exp_q.size()), 32'd0);
    check("long_lv_cyc",  32'(n_lv), 32'd120);
    check("long_crc_err", 32'(n_crc), 32'd0);
    check("long_errs",    32'(n_ecc + n_pkt), 32'd0);
    check("long_lv_end",  32'(bus.lv), 32'd0);
    check("long_fv_kept", 32'(bus.fv), 32'd1);

    // same packet, one payload bit flipped
    clr_counts();
    send_long(HDR_LONG, 120, 37, -1, 1'b1);
    check("flip_pix_cnt", 32'(n_pix), 32'd120);
    check("flip_q_empty", 32'(exp_q.size()), 32'd0);
    check("flip_crc_err", 32'(n_crc), EXP_CRC_FLIP);
    check("flip_pkt_err", 32'(n_pkt + n_ecc), 32'd0);

    // header ECC bit flipped
    clr_counts();
    send_long(HDR_BAD_ECC, 120, -1, -1, 1'b0);
    check("ecc_err_cnt", 32'(n_ecc), 32'd1);
    check("ecc_no_pix",  32'(n_pix), 32'd0);
    check("ecc_no_lv",   32'(n_lv), 32'd0);
    check("ecc_no_pkt",  32'(n_pkt + n_crc), 32'd0);

    // truncated after 10 payload words, then FE
    clr_counts();
    send_long(HDR_LONG, 120, -1, 10, 1'b1);
    check("trunc_pix_cnt", 32'(n_pix), 32'd10);
    check("trunc_q_empty", 32'(exp_q.size()), 32'd0);
    check("trunc_pkt_err", 32'(n_pkt), 32'd1);
    check("trunc_lv_cyc",  32'(n_lv), 32'd10);
    check("trunc_lv_end",  32'(bus.lv), 32'd0);
    check("trunc_fv_kept", 32'(bus.fv), 32'd1);
    check("trunc_state",   32'(dbg_state), 32'(ST_IDLE));
    clr_counts();
    send_short(HDR_FE);
    check("fe_fv", 32'(bus.fv), 32'd0);
    check("fe_errs", 32'(n_ecc + n_crc + n_pkt), 32'd0);

    // word count not a multiple of 4
    clr_counts();
    send_long(HDR_WC_ODD, 120, -1, -1, 1'b0);
    check("wc_pkt_err", 32'(n_pkt), 32'd1);
    check("wc_no_pix",  32'(n_pix), 32'd0);
    check("wc_no_lv",   32'(n_lv), 32'd0);
    check("wc_no_ecc",  32'(n_ecc), 32'd0);

    // reset mid-payload with fv and lv both high
    send_short(HDR_FS);
    clr_counts();
    send_word(HDR_LONG);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(pay(i, 8'hC3));
      send_word(pay(i, 8'hC3));
    end
    @(posedge clk); #1;
    reset       = 1'b1;
    bus.hs_data = 32'hDEAD_0000;
    @(negedge clk);
    check("pre_rst_lv", 32'(bus.lv), 32'd1);
    @(negedge clk);
    check("mid_rst_fv",   32'(bus.fv), 32'd0);
    check("mid_rst_lv",   32'(bus.lv), 32'd0);
    check("mid_rst_pixv", 32'(bus.pix_valid), 32'd0);
    check("mid_rst_pixd", bus.pix_data, 32'd0);
    check("mid_rst_errs", 32'({bus.ecc_err, bus.crc_err, bus.pkt_err}), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    send_word(pay(21, 8'hC3));
    send_word(pay(22, 8'hC3));
    idle(8);
    check("rst_pix_cnt", 32'(n_pix), 32'd20);
    check("rst_q_empty", 32'(exp_q.size()), 32'd0);
    check("rst_no_pkt",  32'(n_pkt + n_ecc + n_crc), 32'd0);
    check("rst_lv_end",  32'(bus.lv), 32'd0);
    send_short(HDR_FS);
    check("rst_recover_fv", 32'(bus.fv), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
